// File: rtl/preload_read_scheduler.sv
// preload_read_scheduler
// Sequences one frame of reads from the preload FIFO into the MAC array.
// A frame starts with a one-cycle FIFO flush. It then streams out_width x out_height
// beats, tagging the last beat of each row and of the frame, and ends with a
// one-cycle done pulse.
// Optional feature: define PRELOAD_SCHED_PERF_EN to add the stall_cycles counter.

module preload_read_scheduler #(
    parameter int FIFO_CNT_W = 3,
    parameter int DIM_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIM_W-1:0]      out_width,
    input  logic [DIM_W-1:0]      out_height,
    input  logic [FIFO_CNT_W-1:0] fifo_cnt,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic                  axis_clear,
    output logic                  mac_valid,
    input  logic                  mac_ready,
    output logic                  mac_row_last,
    output logic                  mac_frame_last,
    output logic                  busy,
    output logic                  done
`ifdef PRELOAD_SCHED_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [DIM_W-1:0] r_width;
    logic [DIM_W-1:0] r_height;
    logic             r_zeroDims;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] r_row;

    logic w_macValid;
    logic w_rowLast;
    logic w_frameLast;
    logic w_beat;
    logic w_axisClear;
    logic w_done;
    logic w_lastCol;
    logic w_lastRow;
    logic w_startAccepted;
    logic w_abortActive;

    // Occupancy is informational only; fifo_empty alone decides whether the head is valid.
    logic w_unusedFifoCnt;
    assign w_unusedFifoCnt = ^fifo_cnt;

    assign w_lastCol       = (r_col == (r_width - DIM_W'(1)));
    assign w_lastRow       = (r_row == (r_height - DIM_W'(1)));
    assign w_startAccepted = (r_state == IDLE) && start;
    assign w_abortActive   = (r_state != IDLE) && abort;

    // Next-state and per-cycle handshake decode; abort wins over beats and completion.
    always_comb begin
        w_stateNext = r_state;
        w_macValid  = 1'b0;
        w_rowLast   = 1'b0;
        w_frameLast = 1'b0;
        w_beat      = 1'b0;
        w_axisClear = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = CLEAR;
                end
            end
            CLEAR: begin
                w_axisClear = 1'b1;
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (r_zeroDims) begin
                    w_stateNext = DONE;
                end else begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                w_macValid  = ~fifo_empty;
                w_rowLast   = w_macValid & w_lastCol;
                w_frameLast = w_rowLast & w_lastRow;
                w_beat      = w_macValid & mac_ready & ~abort;
                if (abort) begin
                    w_axisClear = 1'b1;
                    w_stateNext = IDLE;
                end else if (w_beat && w_frameLast) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    w_axisClear = 1'b1;
                end else begin
                    w_done = 1'b1;
                end
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Reset in flight suppresses every output so a reset mid-frame leaves no trace downstream.
    assign fifo_read      = w_beat & ~rst;
    assign axis_clear     = w_axisClear & ~rst;
    assign mac_valid      = w_macValid & ~rst;
    assign mac_row_last   = w_rowLast & ~rst;
    assign mac_frame_last = w_frameLast & ~rst;
    assign done           = w_done & ~rst;
    assign busy           = (r_state != IDLE) & ~rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Frame geometry is captured once per accepted start and held for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_width    <= '0;
            r_height   <= '0;
            r_zeroDims <= 1'b0;
        end else if (w_startAccepted) begin
            r_width    <= out_width;
            r_height   <= out_height;
            r_zeroDims <= (out_width == '0) || (out_height == '0);
        end
    end

    // Column/row position of the next beat; wraps the column at the end of each row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_startAccepted || w_abortActive || (r_state == DONE)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_beat) begin
            if (w_lastCol) begin
                r_col <= '0;
                r_row <= r_row + DIM_W'(1);
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

`ifdef PRELOAD_SCHED_PERF_EN
    logic [31:0] r_stallCycles;
    assign stall_cycles = r_stallCycles;

    // Counts RUN cycles that move no data, saturating; cleared on each new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
        end else if (w_startAccepted) begin
            r_stallCycles <= '0;
        end else if ((r_state == RUN) && !(w_macValid && mac_ready) &&
                     (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_preload_read_scheduler.sv
// Testbench for preload_read_scheduler.
// A frame-level reference model predicts every output each cycle from the beat
// index of the frame, the latched geometry and the current phase.
// Define PRELOAD_SCHED_PERF_EN to also check stall_cycles.

module tb_preload_read_scheduler;

    localparam int DW = 10;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] outWidth;
    logic [DW-1:0] outHeight;
    logic [CW-1:0] fifoCnt;
    logic          fifoEmpty;
    logic          fifoRead;
    logic          axisClear;
    logic          macValid;
    logic          macReady;
    logic          macRowLast;
    logic          macFrameLast;
    logic          busy;
    logic          done;
`ifdef PRELOAD_SCHED_PERF_EN
    logic [31:0]   stallCycles;
`endif

    int totalCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Reference model: phase 0 idle, 1 flush, 2 streaming, 3 completion.
    int     mPhase = 0;
    int     mW = 0;
    int     mH = 0;
    int     mK = 0;
    int     mBeats = 0;
    int     mDones = 0;
    longint mStall = 0;
    int     obsReads = 0;
    int     obsDones = 0;

    always #5 clk = ~clk;

    preload_read_scheduler #(.FIFO_CNT_W(CW), .DIM_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .out_width      (outWidth),
        .out_height     (outHeight),
        .fifo_cnt       (fifoCnt),
        .fifo_empty     (fifoEmpty),
        .fifo_read      (fifoRead),
        .axis_clear     (axisClear),
        .mac_valid      (macValid),
        .mac_ready      (macReady),
        .mac_row_last   (macRowLast),
        .mac_frame_last (macFrameLast),
        .busy           (busy),
        .done           (done)
`ifdef PRELOAD_SCHED_PERF_EN
        ,
        .stall_cycles   (stallCycles)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at negedge, check before posedge, advance the model at posedge.
    task automatic applyStimulus(input logic s, input logic a, input logic fe, input logic mr);
        logic [6:0] expVec;
        logic [6:0] obsVec;
        logic       beat;
        start     = s;
        abort     = a;
        fifoEmpty = fe;
        macReady  = mr;
        fifoCnt   = fe ? '0 : CW'($urandom_range(1, 7));
        #2;
        expVec = '0;
        beat   = 1'b0;
        if (!rst) begin
            case (mPhase)
                1: expVec = 7'b0100010;
                2: begin
                    beat      = !fe && mr && !a;
                    expVec[6] = beat;
                    expVec[5] = a;
                    expVec[4] = !fe;
                    expVec[3] = !fe && ((mK % mW) == mW - 1);
                    expVec[2] = !fe && (mK == mW * mH - 1);
                    expVec[1] = 1'b1;
                end
                3: begin
                    expVec[5] = a;
                    expVec[1] = 1'b1;
                    expVec[0] = !a;
                end
                default: expVec = '0;
            endcase
        end
        obsVec = {fifoRead, axisClear, macValid, macRowLast, macFrameLast, busy, done};
        checkOutput($sformatf("outputs phase=%0d k=%0d", mPhase, mK), 64'(obsVec), 64'(expVec));
`ifdef PRELOAD_SCHED_PERF_EN
        checkOutput("stallCycles", 64'(stallCycles), 64'(mStall));
`endif
        obsReads += int'(fifoRead);
        obsDones += int'(done);
        @(posedge clk);
        if (rst) begin
            mPhase = 0;
            mK     = 0;
            mStall = 0;
        end else begin
            case (mPhase)
                0: if (s) begin
                    mW = int'(outWidth);
                    mH = int'(outHeight);
                    mK = 0;
                    mStall = 0;
                    mPhase = 1;
                end
                1: mPhase = a ? 0 : ((mW == 0 || mH == 0) ? 3 : 2);
                2: begin
                    if (!(!fe && mr) && mStall < 64'hFFFF_FFFF) mStall++;
                    if (a) begin
                        mPhase = 0;
                        mK = 0;
                    end else if (beat) begin
                        mBeats++;
                        mK++;
                        if (mK == mW * mH) mPhase = 3;
                    end
                end
                3: begin
                    if (!a) mDones++;
                    mPhase = 0;
                    mK = 0;
                end
                default: mPhase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    // Mode 0: always ready; 1: FIFO empty every other cycle; 2: random;
    // 3: abort on beat abortBeat; 4: MAC not ready for the first 5 streaming cycles.
    task automatic runFrame(input int w, input int h, input int mode, input int abortBeat);
        int  runIdx;
        int  i;
        logic s, a, fe, mr;
        mBeats   = 0;
        mDones   = 0;
        obsReads = 0;
        obsDones = 0;
        runIdx   = 0;
        outWidth  = DW'(w);
        outHeight = DW'(h);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (i = 0; i < 300 && mPhase != 0; i++) begin
            s = 1'b0; a = 1'b0; fe = 1'b0; mr = 1'b1;
            case (mode)
                1: fe = i[0];
                2: begin
                    fe = ($urandom_range(0, 2) == 0);
                    mr = ($urandom_range(0, 3) != 0);
                    a  = ($urandom_range(0, 39) == 0);
                    s  = ($urandom_range(0, 7) == 0);
                end
                3: a = (mPhase == 2) && (mK == abortBeat - 1);
                4: mr = (runIdx >= 5);
                default: ;
            endcase
            if (mPhase == 2) runIdx++;
            applyStimulus(s, a, fe, mr);
        end
        checkOutput("frameTimeout", 64'(mPhase), 64'd0);
        checkOutput("beatCount", 64'(obsReads), 64'(mBeats));
        checkOutput("doneCount", 64'(obsDones), 64'(mDones));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; fifoEmpty = 1'b1; macReady = 1'b0;
        outWidth = '0; outHeight = '0; fifoCnt = '0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        // Idle with abort only: nothing happens.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // 3x2, always ready: 6 beats, done once.
        runFrame(3, 2, 0, 0);
        checkOutput("fullFrameBeats", 64'(obsReads), 64'd6);
        checkOutput("fullFrameDone", 64'(obsDones), 64'd1);

        // 3x2 with FIFO empty every other cycle.
        runFrame(3, 2, 1, 0);
        checkOutput("toggleBeats", 64'(obsReads), 64'd6);
        checkOutput("toggleDone", 64'(obsDones), 64'd1);

        // Abort on beat 4 of 3x2.
        runFrame(3, 2, 3, 4);
        checkOutput("abortBeats", 64'(obsReads), 64'd3);
        checkOutput("abortDone", 64'(obsDones), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Zero width and zero height: flush then done, no beats.
        runFrame(0, 2, 0, 0);
        checkOutput("zeroWidthBeats", 64'(obsReads), 64'd0);
        checkOutput("zeroWidthDone", 64'(obsDones), 64'd1);
        runFrame(4, 0, 0, 0);

        // Reset mid-frame: no done, no flush, outputs quiet.
        outWidth = DW'(3); outHeight = DW'(2);
        obsDones = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("resetNoDone", 64'(obsDones), 64'd0);

        // Stall profile: 2x1 with MAC not ready for 5 streaming cycles.
        runFrame(2, 1, 4, 0);
`ifdef PRELOAD_SCHED_PERF_EN
        checkOutput("stallAfterDone", 64'(stallCycles), 64'd5);
        outWidth = DW'(1); outHeight = DW'(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("stallClearedOnStart", 64'(stallCycles), 64'd0);
        for (int j = 0; j < 10 && mPhase != 0; j++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            runFrame($urandom_range(1, 4), $urandom_range(1, 3), 2, 0);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
